// File: rtl/lc3b_types.sv
// Shared LC-3b types and multiply/divide unit constants.
package lc3b_types;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned MD_ITERS = 16;
    localparam int unsigned MD_CNT_W = $clog2(MD_ITERS);
    localparam logic [MD_CNT_W-1:0] MD_CNT_LAST = MD_CNT_W'(MD_ITERS - 1);

    typedef logic [WORD_W-1:0] lc3b_word;

    // Encodings match the control word's lc3x_mux_sel field, which drives op_sel directly.
    typedef enum logic [1:0] {
        md_mult = 2'b01,
        md_div  = 2'b10
    } lc3x_md_op;

    // Two's-complement negate at word width.
    function automatic lc3b_word neg_word(input lc3b_word w);
        return lc3b_word'(~w + WORD_W'(1));
    endfunction

    // Magnitude of a signed word; 16'h8000 maps to itself, read as unsigned 32768.
    function automatic lc3b_word abs_word(input lc3b_word w);
        return w[WORD_W-1] ? neg_word(w) : w;
    endfunction

endpackage

// File: rtl/mult_div_datapath.sv
// Iterative shift-add multiplier / restoring divider datapath.
// Multiply: r_a = multiplicand (shifts left), r_b = multiplier (shifts right), r_acc = product.
// Divide:   r_a = |dividend| becoming quotient, r_b = |divisor|, r_acc = partial remainder.
module mult_div_datapath
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     i_load,
    input  logic     i_step,
    input  logic     i_is_div,
    input  lc3b_word i_srca,
    input  lc3b_word i_srcb,
    output lc3b_word o_result_c
);

    logic            r_is_div;
    logic            r_neg;
    lc3b_word        r_a;
    lc3b_word        r_b;
    lc3b_word        r_acc;

    logic [WORD_W:0] w_rem_sh;
    logic [WORD_W:0] w_diff;
    logic            w_fits;
    lc3b_word        w_add;
    lc3b_word        w_a_nxt;
    lc3b_word        w_b_nxt;
    lc3b_word        w_acc_nxt;

    // One iteration of the selected algorithm; result reflects the post-step values.
    always_comb begin
        w_rem_sh   = {r_acc, r_a[WORD_W-1]};
        w_diff     = w_rem_sh - {1'b0, r_b};
        w_fits     = ~w_diff[WORD_W];
        w_add      = r_b[0] ? r_a : '0;
        w_a_nxt    = r_a;
        w_b_nxt    = r_b;
        w_acc_nxt  = r_acc;
        o_result_c = r_acc;
        if (r_is_div) begin
            w_acc_nxt  = w_fits ? w_diff[WORD_W-1:0] : w_rem_sh[WORD_W-1:0];
            w_a_nxt    = {r_a[WORD_W-2:0], w_fits};
            o_result_c = r_neg ? neg_word(w_a_nxt) : w_a_nxt;
        end else begin
            w_acc_nxt  = r_acc + w_add;
            w_a_nxt    = {r_a[WORD_W-2:0], 1'b0};
            w_b_nxt    = {1'b0, r_b[WORD_W-1:1]};
            o_result_c = w_acc_nxt;
        end
    end

    // Operand capture on load, one iteration per step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
        end else if (i_load) begin
            r_is_div <= i_is_div;
            r_neg    <= i_srca[WORD_W-1] ^ i_srcb[WORD_W-1];
            r_a      <= i_is_div ? abs_word(i_srca) : i_srca;
            r_b      <= i_is_div ? abs_word(i_srcb) : i_srcb;
            r_acc    <= '0;
        end else if (i_step) begin
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_acc    <= w_acc_nxt;
        end
    end

endmodule

// File: rtl/lc3x_mult_div.sv
// LC-3X multi-cycle multiply/divide unit: IDLE -> RUN (16 iterations) -> DONE.
module lc3x_mult_div
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op_sel,
    input  lc3b_word   srca,
    input  lc3b_word   srcb,
    input  logic       flush,
    output logic       busy,
    output logic       done,
    output lc3b_word   result,
    output logic       div_zero
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]          r_state;
    logic [MD_CNT_W-1:0] r_cnt;

    logic [1:0]          w_next;
    logic                w_load;
    logic                w_step;
    logic                w_fin;
    logic                w_dz;
    logic                w_is_div;
    logic                w_valid_op;
    lc3b_word            w_dp_result_c;

    assign w_is_div   = (op_sel == md_div);
    assign w_valid_op = (op_sel == md_mult) || w_is_div;

    // Next-state and datapath control.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        w_fin  = 1'b0;
        w_dz   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!flush && start && w_valid_op) begin
                    w_load = 1'b1;
                    if (w_is_div && (srcb == '0)) begin
                        w_dz   = 1'b1;
                        w_next = S_DONE;
                    end else begin
                        w_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == MD_CNT_LAST) begin
                        w_fin  = 1'b1;
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State, iteration counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            result   <= '0;
        end else begin
            r_state  <= w_next;
            busy     <= (w_next != S_IDLE);
            done     <= (w_next == S_DONE);
            div_zero <= w_dz;
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + MD_CNT_W'(1);
            end
            if (w_dz) begin
                result <= '1;
            end else if (w_fin) begin
                result <= w_dp_result_c;
            end
        end
    end

    mult_div_datapath u_datapath (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_is_div   (w_is_div),
        .i_srca     (srca),
        .i_srcb     (srcb),
        .o_result_c (w_dp_result_c)
    );

endmodule

// File: tb/tb_lc3x_mult_div.sv
// Self-checking bench for lc3x_mult_div: directed scenarios plus randomized ops vs. an arithmetic model.
// Timing convention: "edge 0" is the rising edge that samples start; outputs are sampled 1 ns after
// each edge. A normal op shows done after edge 16 (the 17th cycle after the start edge);
// a divide-by-zero shows done right after edge 0.
module tb_lc3x_mult_div;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op_sel;
    logic [15:0] srca;
    logic [15:0] srcb;
    logic        flush;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    localparam int NORMAL_LAT = 16;
    localparam int MAX_WAIT   = 40;

    lc3x_mult_div dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op_sel   (op_sel),
        .srca     (srca),
        .srcb     (srcb),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: low product word, or signed quotient truncated toward zero.
    function automatic logic [15:0] ref_md(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        longint p;
        int sa, sb, q;
        if (op == 2'b01) begin
            p = longint'(a) * longint'(b);
            return p[15:0];
        end
        if (b == 16'h0000) return 16'hFFFF;
        sa = int'($signed(a));
        sb = int'($signed(b));
        q  = sa / sb;
        return q[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op for exactly one edge, then scramble operand inputs to prove they were captured.
    task automatic launch(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        op_sel = op;
        srca   = a;
        srcb   = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        op_sel = 2'($urandom_range(0, 3));
        srca   = 16'($urandom);
        srcb   = 16'($urandom);
    endtask

    // Edges after edge 0 until done is seen; seen=0 if the budget expires.
    task automatic wait_done(output int cyc, output logic seen);
        cyc  = 0;
        seen = done;
        while (!seen && cyc < MAX_WAIT) begin
            tick();
            cyc++;
            seen = done;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; flush = 1'b0; op_sel = 2'b00; srca = '0; srcb = '0;
        tick(); tick();
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (div_zero !== 1'b0)    begin errors++; $display("FAIL reset_dz got %b want 0", div_zero); end
        checks++; if (result !== 16'h0000)  begin errors++; $display("FAIL reset_result got %h want 0000", result); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mult_directed();
        int cyc; logic seen;
        launch(2'b01, 16'h0007, 16'hFFFD);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy_start got %b want 1", busy); end
        wait_done(cyc, seen);
        checks++; if (!seen || cyc != NORMAL_LAT) begin errors++; $display("FAIL mult_latency got %0d seen=%b want %0d", cyc, seen, NORMAL_LAT); end
        checks++; if (result !== 16'hFFEB) begin errors++; $display("FAIL mult_result got %h want ffeb", result); end
        checks++; if (div_zero !== 1'b0)   begin errors++; $display("FAIL mult_dz got %b want 0", div_zero); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_width got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_after got %b want 0", busy); end
        checks++; if (result !== 16'hFFEB) begin errors++; $display("FAIL mult_result_hold got %h want ffeb", result); end
    endtask

    task automatic test_div_directed();
        int cyc; logic seen;
        logic [15:0] va [2] = '{16'hFFF9, 16'h8000};
        logic [15:0] vb [2] = '{16'h0002, 16'hFFFF};
        logic [15:0] ve [2] = '{16'hFFFD, 16'h8000};
        for (int i = 0; i < 2; i++) begin
            launch(2'b10, va[i], vb[i]);
            wait_done(cyc, seen);
            checks++; if (!seen || cyc != NORMAL_LAT) begin errors++; $display("FAIL div_latency[%0d] got %0d seen=%b want %0d", i, cyc, seen, NORMAL_LAT); end
            checks++; if (result !== ve[i]) begin errors++; $display("FAIL div_result[%0d] got %h want %h", i, result, ve[i]); end
            checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL div_dz[%0d] got %b want 0", i, div_zero); end
            tick();
        end
    endtask

    task automatic test_div_zero();
        int cyc; logic seen;
        launch(2'b10, 16'h1234, 16'h0000);
        wait_done(cyc, seen);
        checks++; if (!seen || cyc != 0) begin errors++; $display("FAIL dz_latency got %0d seen=%b want 0", cyc, seen); end
        checks++; if (result !== 16'hFFFF) begin errors++; $display("FAIL dz_result got %h want ffff", result); end
        checks++; if (div_zero !== 1'b1)   begin errors++; $display("FAIL dz_flag got %b want 1", div_zero); end
        tick();
        checks++; if (div_zero !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL dz_after got dz=%b done=%b busy=%b want 0 0 0", div_zero, done, busy);
        end
        checks++; if (result !== 16'hFFFF) begin errors++; $display("FAIL dz_result_hold got %h want ffff", result); end
    endtask

    task automatic test_start_while_busy();
        int ndone = 0;
        logic [15:0] exp = ref_md(2'b01, 16'h0123, 16'h0045);
        launch(2'b01, 16'h0123, 16'h0045);
        for (int c = 1; c <= 30; c++) begin
            if (c == 5) begin
                op_sel = 2'b10; srca = 16'h7FFF; srcb = 16'h0003; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                checks++; if (result !== exp) begin errors++; $display("FAIL busy_start_result got %h want %h", result, exp); end
            end
            tick();
        end
        start = 1'b0;
        checks++; if (ndone != 1) begin errors++; $display("FAIL busy_start_done_count got %0d want 1", ndone); end
    endtask

    task automatic test_flush();
        int cyc; logic seen; int ndone = 0;
        logic [15:0] prev = result;
        launch(2'b01, 16'h1111, 16'h0009);
        for (int c = 1; c < 8; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_idle got busy=%b done=%b want 0 0", busy, done); end
        for (int c = 0; c < 20; c++) begin
            if (done) ndone++;
            tick();
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL flush_no_done got %0d want 0", ndone); end
        checks++; if (result !== prev) begin errors++; $display("FAIL flush_result_hold got %h want %h", result, prev); end
        launch(2'b01, 16'h00FF, 16'h0101);
        wait_done(cyc, seen);
        checks++; if (!seen || cyc != NORMAL_LAT || result !== 16'hFFFF) begin
            errors++; $display("FAIL flush_restart got cyc=%0d seen=%b res=%h want %0d 1 ffff", cyc, seen, result, NORMAL_LAT);
        end
        tick();
    endtask

    task automatic test_idle_ignores();
        int ndone = 0;
        logic [15:0] prev = result;
        // flush beats start; invalid op codes are not operations.
        flush = 1'b1;
        launch(2'b01, 16'h0003, 16'h0003);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_idle got busy=%b want 0", busy); end
        launch(2'b00, 16'h0003, 16'h0003);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL invalid_op00 got busy=%b want 0", busy); end
        launch(2'b11, 16'h0003, 16'h0000);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL invalid_op11 got busy=%b want 0", busy); end
        for (int c = 0; c < 20; c++) begin
            if (done) ndone++;
            tick();
        end
        checks++; if (ndone != 0 || result !== prev) begin errors++; $display("FAIL idle_ignore got dones=%0d res=%h want 0 %h", ndone, result, prev); end
    endtask

    task automatic test_async_reset();
        int ndone = 0;
        launch(2'b01, 16'h0005, 16'h0006);
        for (int c = 0; c < 6; c++) tick();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL areset_result got %h want 0000", result); end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (done || busy) ndone++;
            tick();
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL areset_no_done got %0d active cycles want 0", ndone); end
    endtask

    task automatic test_random();
        int cyc; logic seen;
        logic [1:0]  op;
        logic [15:0] a, b, exp, prev;
        int lat;
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            a  = 16'($urandom);
            b  = 16'($urandom);
            case ($urandom_range(0, 7))
                0: b = 16'h0000;
                1: begin a = 16'h8000; b = 16'hFFFF; end
                2: b = 16'($urandom_range(1, 7));
                default: ;
            endcase
            exp  = ref_md(op, a, b);
            lat  = (op == 2'b10 && b == 16'h0000) ? 0 : NORMAL_LAT;
            prev = result;
            launch(op, a, b);
            if (lat != 0) begin
                checks++; if (result !== prev) begin errors++; $display("FAIL rand_hold[%0d] got %h want %h", n, result, prev); end
            end
            wait_done(cyc, seen);
            checks++; if (!seen || cyc != lat) begin errors++; $display("FAIL rand_latency[%0d] got %0d seen=%b want %0d", n, cyc, seen, lat); end
            checks++; if (result !== exp) begin errors++; $display("FAIL rand_result[%0d] op=%b a=%h b=%h got %h want %h", n, op, a, b, result, exp); end
            checks++; if (div_zero !== (lat == 0)) begin errors++; $display("FAIL rand_dz[%0d] got %b want %b", n, div_zero, lat == 0); end
            tick();
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rand_after[%0d] got done=%b busy=%b want 0 0", n, done, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_div_directed();
        test_div_zero();
        test_start_while_busy();
        test_flush();
        test_idle_ignores();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
